// File: rtl/timelock_iterator.sv
// timelock_iterator
//   Sequencer between the host command controller and one carry-save timelock
//   squaring engine. Runs a programmable number of back-to-back engine
//   iterations, feeding each result (ys/yc) back as the next operand (xs/xc),
//   guards every iteration with a watchdog and reports the final carry-save
//   value together with a one-cycle done pulse.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no job; eng_ld=1, waiting for start
//   LOAD   | eng_ld=1 with stable operands for LD_CYCLES cycles
//   RUN    | eng_ld=0, engine computing; waiting for eng_dn or watchdog
//   FINISH | one cycle; publish out_s/out_c, pulse done, drop busy
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   start, abort          job request pulse / cancel current job
//   in_s, in_c, count     initial carry-save value and iteration count
//   busy, done            job in progress / one-cycle completion pulse
//   err_timeout           last job ended by watchdog (sticky until next start)
//   out_s, out_c          final carry-save value of the last completed job
//   iters_done            iterations completed in the current/last job
//   eng_ld, eng_xs/xc     engine load control and operands
//   eng_dn, eng_ys/yc     engine result valid and result

module timelock_iterator #(
  parameter int WIDTH     = 184,
  parameter int CNT_W     = 32,
  parameter int LD_CYCLES = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_s,
  input  logic [WIDTH-1:0] in_c,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [WIDTH-1:0] out_s,
  output logic [WIDTH-1:0] out_c,
  output logic [CNT_W-1:0] iters_done,
  output logic             eng_ld,
  output logic [WIDTH-1:0] eng_xs,
  output logic [WIDTH-1:0] eng_xc,
  input  logic             eng_dn,
  input  logic [WIDTH-1:0] eng_ys,
  input  logic [WIDTH-1:0] eng_yc
);

  localparam int LD_W = (LD_CYCLES > 1) ? $clog2(LD_CYCLES) : 1;
  localparam int WD_W = $clog2(TIMEOUT);

  // Both timers are down-counters; the terminal count is zero.
  localparam logic [LD_W-1:0]  LD_LOAD = LD_W'(LD_CYCLES - 1);
  localparam logic [LD_W-1:0]  LD_ONE  = LD_W'(1);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work_s;
  logic [WIDTH-1:0] work_c;
  logic [CNT_W-1:0] remaining;
  logic [LD_W-1:0]  ld_tmr;
  logic [WD_W-1:0]  wdog;

  // wdog still at its load value means this is the first RUN cycle, where a
  // dn left over from the previous iteration must not be taken as a result.
  logic run_first;
  assign run_first = (wdog == WD_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      out_s       <= '0;
      out_c       <= '0;
      iters_done  <= '0;
      eng_ld      <= 1'b1;
      eng_xs      <= '0;
      eng_xc      <= '0;
      work_s      <= '0;
      work_c      <= '0;
      remaining   <= '0;
      ld_tmr      <= '0;
      wdog        <= '0;
    end else begin
      done <= 1'b0;

      if (abort && (state != S_IDLE)) begin
        // Cancel: keep outputs, err flag and progress as they are.
        state  <= S_IDLE;
        busy   <= 1'b0;
        eng_ld <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            eng_ld <= 1'b1;
            if (start && !abort) begin
              // Operand registers are written together with the working
              // registers so they are already stable on the first LOAD cycle.
              work_s      <= in_s;
              work_c      <= in_c;
              eng_xs      <= in_s;
              eng_xc      <= in_c;
              remaining   <= count;
              iters_done  <= '0;
              err_timeout <= 1'b0;
              busy        <= 1'b1;
              ld_tmr      <= LD_LOAD;
              state       <= (count == '0) ? S_FINISH : S_LOAD;
            end
          end

          S_LOAD: begin
            eng_ld <= 1'b1;
            if (ld_tmr == '0) begin
              state  <= S_RUN;
              eng_ld <= 1'b0;
              wdog   <= WD_LOAD;
            end else begin
              ld_tmr <= ld_tmr - LD_ONE;
            end
          end

          S_RUN: begin
            if (eng_dn && !run_first) begin
              // A result in the terminal watchdog cycle still counts.
              work_s     <= eng_ys;
              work_c     <= eng_yc;
              eng_xs     <= eng_ys;
              eng_xc     <= eng_yc;
              remaining  <= remaining - CNT_ONE;
              iters_done <= iters_done + CNT_ONE;
              wdog       <= WD_LOAD;
              eng_ld     <= 1'b1;
              ld_tmr     <= LD_LOAD;
              state      <= (remaining == CNT_ONE) ? S_FINISH : S_LOAD;
            end else if (wdog == '0) begin
              err_timeout <= 1'b1;
              eng_ld      <= 1'b1;
              state       <= S_FINISH;
            end else begin
              wdog <= wdog - WD_ONE;
            end
          end

          S_FINISH: begin
            out_s  <= work_s;
            out_c  <= work_c;
            done   <= 1'b1;
            busy   <= 1'b0;
            eng_ld <= 1'b1;
            state  <= S_IDLE;
          end

          default: begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            eng_ld <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timelock_iterator.sv
module tb_timelock_iterator;

  localparam int W   = 184;
  localparam int CW  = 32;
  localparam int LDC = 2;
  localparam int TO  = 16;
  localparam logic [W-1:0] ONE_W = W'(1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  in_s = '0;
  logic [W-1:0]  in_c = '0;
  logic [CW-1:0] count = '0;
  logic          busy, done, err_timeout;
  logic [W-1:0]  out_s, out_c;
  logic [CW-1:0] iters_done;
  logic          eng_ld;
  logic [W-1:0]  eng_xs, eng_xc;
  logic          eng_dn;
  logic [W-1:0]  eng_ys, eng_yc;

  int checks = 0;
  int errors = 0;

  timelock_iterator #(.WIDTH(W), .CNT_W(CW), .LD_CYCLES(LDC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_s(in_s), .in_c(in_c), .count(count),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .out_s(out_s), .out_c(out_c), .iters_done(iters_done),
    .eng_ld(eng_ld), .eng_xs(eng_xs), .eng_xc(eng_xc),
    .eng_dn(eng_dn), .eng_ys(eng_ys), .eng_yc(eng_yc)
  );

  always #5 clk = ~clk;

  // Engine stub: dn from the 6th cycle of ld low, ys = xs + xc + 1, yc = 0.
  bit stub_en = 1'b1;
  int lo_cnt = 0;
  always @(posedge clk) lo_cnt <= eng_ld ? 0 : lo_cnt + 1;
  assign eng_dn = stub_en && !eng_ld && (lo_cnt >= 5);
  assign eng_ys = eng_xs + eng_xc + ONE_W;
  assign eng_yc = '0;

  // Activity monitor, sampled 2 time units after each rising edge.
  int  done_cnt = 0, ld_falls = 0, bad_gap = 0, lo_len = 0, last_lo_len = 0, hi_busy = 0;
  bit  prev_ld = 1'b1;
  always @(posedge clk) begin
    #2;
    if (done) done_cnt++;
    if (!eng_ld) begin
      if (prev_ld) begin
        ld_falls++;
        if (hi_busy != LDC) bad_gap++;
      end
      lo_len++;
    end else begin
      if (!prev_ld) last_lo_len = lo_len;
      lo_len = 0;
    end
    if (busy && eng_ld) hi_busy++; else hi_busy = 0;
    prev_ld = eng_ld;
  end

  // Reference model: every iteration collapses the carry-save pair and adds 1.
  function automatic logic [W-1:0] model_s(input logic [W-1:0] s, input logic [W-1:0] c, input logic [CW-1:0] n);
    return (n == '0) ? s : s + c + W'(n);
  endfunction
  function automatic logic [W-1:0] model_c(input logic [W-1:0] c, input logic [CW-1:0] n);
    return (n == '0) ? c : '0;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r = '0;
    for (int i = 0; i < 6; i++) r = (r << 32) | W'($urandom());
    return r;
  endfunction

  task automatic clear_stats();
    done_cnt = 0; ld_falls = 0; bad_gap = 0; last_lo_len = 0;
  endtask

  task automatic start_job(input logic [W-1:0] s, input logic [W-1:0] c, input logic [CW-1:0] n);
    in_s = s; in_c = c; count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  logic [W-1:0] last_s = '0, last_c = '0;

  task automatic test_reset();
    rst = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_timeout); end
    checks++; if (eng_ld !== 1'b1) begin errors++; $display("FAIL reset_eng_ld got %b exp 1", eng_ld); end
    checks++; if (iters_done !== '0) begin errors++; $display("FAIL reset_iters got %0d exp 0", iters_done); end
    checks++; if (out_s !== '0 || out_c !== '0) begin errors++; $display("FAIL reset_out got %h/%h exp 0/0", out_s, out_c); end
    checks++; if (eng_xs !== '0 || eng_xc !== '0) begin errors++; $display("FAIL reset_eng_x got %h/%h exp 0/0", eng_xs, eng_xc); end
  endtask

  task automatic test_single();
    bit ok;
    clear_stats();
    start_job(W'(3), W'(4), CW'(1));
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done got none exp pulse"); end
    checks++; if (out_s !== W'(8) || out_c !== '0) begin errors++; $display("FAIL single_out got %h/%h exp 8/0", out_s, out_c); end
    checks++; if (iters_done !== CW'(1)) begin errors++; $display("FAIL single_iters got %0d exp 1", iters_done); end
    checks++; if (err_timeout !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_flags got err=%b busy=%b exp 0/0", err_timeout, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || done_cnt != 1) begin errors++; $display("FAIL single_pulse got done=%b count=%0d exp 0/1", done, done_cnt); end
    checks++; if (ld_falls != 1 || last_lo_len != 6) begin errors++; $display("FAIL single_run_window got falls=%0d len=%0d exp 1/6", ld_falls, last_lo_len); end
    last_s = W'(8); last_c = '0;
  endtask

  task automatic test_chain();
    bit ok;
    clear_stats();
    start_job(W'(1), W'(0), CW'(3));
    wait_done(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL chain_done got none exp pulse"); end
    checks++; if (out_s !== W'(4) || out_c !== '0) begin errors++; $display("FAIL chain_out got %h/%h exp 4/0", out_s, out_c); end
    checks++; if (iters_done !== CW'(3)) begin errors++; $display("FAIL chain_iters got %0d exp 3", iters_done); end
    @(negedge clk);
    checks++; if (ld_falls != 3 || bad_gap != 0) begin errors++; $display("FAIL chain_ld_shape got falls=%0d bad_gaps=%0d exp 3/0", ld_falls, bad_gap); end
    last_s = W'(4); last_c = '0;
  endtask

  task automatic test_zero();
    clear_stats();
    start_job(W'(8'hAB), W'(1), CW'(0));
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_cycle1 got done=%b busy=%b exp 0/1", done, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_cycle2 got done=%b busy=%b exp 1/0", done, busy); end
    checks++; if (out_s !== W'(8'hAB) || out_c !== W'(1)) begin errors++; $display("FAIL zero_out got %h/%h exp ab/1", out_s, out_c); end
    checks++; if (iters_done !== '0) begin errors++; $display("FAIL zero_iters got %0d exp 0", iters_done); end
    @(negedge clk);
    checks++; if (ld_falls != 0) begin errors++; $display("FAIL zero_ld_falls got %0d exp 0", ld_falls); end
    last_s = W'(8'hAB); last_c = W'(1);
  endtask

  task automatic test_timeout();
    bit ok;
    logic [W-1:0] s, c;
    s = rand_w(); c = rand_w();
    clear_stats();
    stub_en = 1'b0;
    start_job(s, c, CW'(2));
    wait_done(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL timeout_done got none exp pulse"); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_err got %b exp 1", err_timeout); end
    checks++; if (iters_done !== '0) begin errors++; $display("FAIL timeout_iters got %0d exp 0", iters_done); end
    checks++; if (out_s !== s || out_c !== c) begin errors++; $display("FAIL timeout_out got %h/%h exp %h/%h", out_s, out_c, s, c); end
    checks++; if (last_lo_len != TO) begin errors++; $display("FAIL timeout_run_len got %0d exp %0d", last_lo_len, TO); end
    stub_en = 1'b1;
    @(negedge clk);
    s = rand_w(); c = rand_w();
    start_job(s, c, CW'(1));
    checks++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_clear got err=%b busy=%b exp 0/1", err_timeout, busy); end
    wait_done(100, ok);
    checks++; if (!ok || out_s !== model_s(s, c, CW'(1)) || out_c !== '0) begin errors++; $display("FAIL timeout_next_job got %h exp %h", out_s, model_s(s, c, CW'(1))); end
    last_s = model_s(s, c, CW'(1)); last_c = '0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit ok;
    clear_stats();
    start_job(rand_w(), rand_w(), CW'(5));
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (iters_done == CW'(2) && eng_dn) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL abort_reach_iter3 got none exp dn on iteration 3"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || eng_ld !== 1'b1) begin errors++; $display("FAIL abort_state got busy=%b ld=%b exp 0/1", busy, eng_ld); end
    checks++; if (iters_done !== CW'(2)) begin errors++; $display("FAIL abort_iters got %0d exp 2", iters_done); end
    checks++; if (out_s !== last_s || out_c !== last_c) begin errors++; $display("FAIL abort_out got %h/%h exp %h/%h", out_s, out_c, last_s, last_c); end
    repeat (20) @(negedge clk);
    checks++; if (done_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done got dones=%0d busy=%b exp 0/0", done_cnt, busy); end
    // abort and start together while idle: start is dropped
    in_s = rand_w(); in_c = rand_w(); count = CW'(1); start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || iters_done !== CW'(2)) begin errors++; $display("FAIL abort_start_idle got busy=%b iters=%0d exp 0/2", busy, iters_done); end
  endtask

  task automatic test_busy_start();
    bit ok;
    logic [W-1:0] s, c;
    s = rand_w(); c = rand_w();
    clear_stats();
    start_job(s, c, CW'(2));
    repeat (4) @(negedge clk);
    start_job(rand_w(), rand_w(), CW'(1));
    wait_done(200, ok);
    checks++; if (!ok || out_s !== model_s(s, c, CW'(2)) || out_c !== '0) begin errors++; $display("FAIL busy_start_result got %h exp %h", out_s, model_s(s, c, CW'(2))); end
    checks++; if (iters_done !== CW'(2)) begin errors++; $display("FAIL busy_start_iters got %0d exp 2", iters_done); end
    repeat (30) @(negedge clk);
    checks++; if (done_cnt != 1 || busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued got dones=%0d busy=%b exp 1/0", done_cnt, busy); end
    last_s = model_s(s, c, CW'(2)); last_c = '0;
  endtask

  task automatic test_done_start();
    bit ok;
    logic [W-1:0] s, c;
    start_job(rand_w(), rand_w(), CW'(1));
    wait_done(100, ok);
    s = rand_w(); c = rand_w();
    start_job(s, c, CW'(2));
    checks++; if (!ok || busy !== 1'b1) begin errors++; $display("FAIL done_start_accept got busy=%b exp 1", busy); end
    wait_done(200, ok);
    checks++; if (!ok || out_s !== model_s(s, c, CW'(2)) || iters_done !== CW'(2)) begin errors++; $display("FAIL done_start_result got %h iters=%0d exp %h iters=2", out_s, iters_done, model_s(s, c, CW'(2))); end
    last_s = model_s(s, c, CW'(2)); last_c = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit ok;
    logic [W-1:0] s, c;
    logic [CW-1:0] n;
    for (int k = 0; k < 8; k++) begin
      s = rand_w(); c = rand_w(); n = CW'($urandom_range(0, 4));
      start_job(s, c, n);
      wait_done(200, ok);
      checks++;
      if (!ok || out_s !== model_s(s, c, n) || out_c !== model_c(c, n) || iters_done !== n || err_timeout !== 1'b0) begin
        errors++;
        $display("FAIL random_job%0d got %h/%h iters=%0d exp %h/%h iters=%0d", k, out_s, out_c, iters_done, model_s(s, c, n), model_c(c, n), n);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_rst();
    bit ok;
    clear_stats();
    start_job(rand_w(), rand_w(), CW'(3));
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!eng_ld) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach_run got ld=%b exp 0", eng_ld); end
    #1 rst = 1'b1;
    #1;
    checks++; if (eng_ld !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_async got ld=%b busy=%b exp 1/0", eng_ld, busy); end
    checks++; if (out_s !== '0 || iters_done !== '0) begin errors++; $display("FAIL rst_values got out=%h iters=%0d exp 0/0", out_s, iters_done); end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (done_cnt != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_done got dones=%0d busy=%b exp 0/0", done_cnt, busy); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit got no finish exp finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_zero();
    test_timeout();
    test_abort();
    test_busy_start();
    test_done_start();
    test_random();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timelock_iterator.md
Name: timelock_iterator

Overview:
Sequencer that drives the carry-save timelock squaring engine through a programmable number of back-to-back iterations. It feeds each result (ys/yc) back as the next input (xs/xc) and enforces the engine's ld/dn protocol. It guards each iteration with a watchdog and reports the final carry-save value with a single-cycle done pulse. It sits between the host-side command controller and one engine instance.

Parameters:
WIDTH, 184, width of each carry-save half (xs, xc, ys, yc)
CNT_W, 32, width of iteration count and progress counter
LD_CYCLES, 2, cycles eng_ld is held high with stable operands per iteration (>=1)
TIMEOUT, 65535, max RUN cycles per iteration before watchdog error (>=2)

Ports:
clk  in  1  single clock for block and engine
rst  in  1  asynchronous, active-high reset
start  in  1  request pulse; accepted only when busy=0
abort  in  1  cancel current job
in_s  in  WIDTH  initial sum half
in_c  in  WIDTH  initial carry half
count  in  CNT_W  number of iterations
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
err_timeout  out  1  last job ended by watchdog; sticky until next accepted start
out_s  out  WIDTH  final sum half
out_c  out  WIDTH  final carry half
iters_done  out  CNT_W  iterations completed in current/last job
eng_ld  out  1  engine load (1=load/hold, 0=compute)
eng_xs  out  WIDTH  engine sum operand
eng_xc  out  WIDTH  engine carry operand
eng_dn  in  1  engine result valid
eng_ys  in  WIDTH  engine sum result
eng_yc  in  WIDTH  engine carry result

Behaviour:
- Reset values (async): state IDLE, eng_ld=1, busy=0, done=0, err_timeout=0, iters_done=0. All data registers are 0: out_s, out_c, eng_xs, eng_xc, working regs.
- eng_xs/eng_xc are registered copies of the working regs, valid whenever eng_ld=1.
- IDLE: eng_ld=1. On start=1 and abort=0:
  - latch in_s/in_c into working regs and count into remaining;
  - clear iters_done and err_timeout; busy=1 next cycle.
  - count=0: go to FINISH; otherwise go to LOAD.
- LOAD: eng_ld=1 for exactly LD_CYCLES cycles with operands stable, then RUN.
- RUN: eng_ld=0; watchdog counts from 0.
  - eng_dn is ignored in the first RUN cycle, to avoid a stale dn.
  - On the first later cycle with eng_dn=1: working <= eng_ys/eng_yc, remaining-1, iters_done+1, watchdog cleared. If remaining was 1, go to FINISH; else go to LOAD.
  - If the watchdog reaches TIMEOUT-1 with no dn: err_timeout<=1, go to FINISH without updating working regs or iters_done.
  - dn wins over timeout in the same cycle.
- FINISH (one cycle): out_s/out_c <= working regs, done<=1, busy<=0, eng_ld=1, go to IDLE.
  - done, busy=0 and the new out_* become visible on the same clock edge.
  - done lasts exactly one cycle.
  - A start presented in the cycle done=1 is accepted.
- abort=1 while busy (any state), priority over dn, timeout and FINISH:
  - next edge: IDLE, eng_ld=1, busy=0;
  - no done pulse; out_s/out_c and err_timeout unchanged; iters_done holds progress.
- abort=1 with start=1 in IDLE: abort wins, start ignored.
- start while busy=1: ignored, no queuing.
- remaining and iters_done never wrap: maximum is 2^CNT_W-1 iterations, and iters_done equals count on success.
- Async rst mid-job: immediate return to reset values, including eng_ld=1. No done pulse.

Test Plan:
Engine stub for all scenarios: dn 5 cycles after ld falls, ys=xs+xc+1 (mod 2^WIDTH), yc=0.
1. Single job: in_s=3, in_c=4, count=1 -> exactly one done pulse; out_s=8, out_c=0, iters_done=1, err_timeout=0; eng_ld low for exactly one RUN window.
2. Chained job: in_s=1, in_c=0, count=3 -> out_s=4 (values 2, 3, 4), iters_done=3; eng_ld high for LD_CYCLES=2 cycles before each of 3 RUN windows.
3. Zero count: count=0, in_s=0xAB, in_c=0x1 -> done 2 cycles after start; out_s=0xAB, out_c=1, iters_done=0; eng_ld never falls.
4. Timeout: stub never asserts dn, TIMEOUT=16, count=2 -> done after 16 RUN cycles; err_timeout=1, iters_done=0, out = inputs. The next accepted start clears err_timeout.
5. Abort: count=5, assert abort in the cycle stub dn rises on iteration 3 -> no done pulse, busy=0 next cycle, iters_done=2, eng_ld=1, out_s/out_c unchanged from the previous job.
6. Corner cases:
   - start while busy is ignored;
   - start in the done cycle begins a new job;
   - rst asserted mid-RUN forces eng_ld=1 and busy=0 asynchronously, before the next clock edge.
